ftdi_pkt_engine: RTL

Parametrised packet processor between the ftdiController byte stream and host software. It replaces the fixed two-byte invert/echo logic with framed packets of the form {opcode, length, payload[length]}. Each payload is buffered, one of several transforms is applied, and a framed response is returned through a backpressured TX handshake. It also adds an inter-byte timeout, error accounting and packet statistics.

---
 rtl/ftdi_pkt_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ftdi_pkt_engine.sv
// ftdi_pkt_engine: framed {opcode,len,payload} processor with echo/invert/reverse/sum
// responses, inter-byte timeout, saturating error count and packet statistics.
module ftdi_pkt_engine #(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ERR_BYTE       = 8'hEE,
  parameter logic [7:0] OP_ECHO        = 8'h00,
  parameter logic [7:0] OP_INV         = 8'hAA,
  parameter logic [7:0] OP_REV         = 8'h33,
  parameter logic [7:0] OP_SUM         = 8'hE0
) (
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic [7:0]  in_rx_data,
  input  logic        in_rx_valid,
  output logic        out_rx_ena,
  output logic [7:0]  out_tx_data,
  output logic        out_tx_valid,
  input  logic        in_tx_ready,
  output logic        out_busy,
  output logic [7:0]  out_err_count,
  output logic [15:0] out_pkt_count
);
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, RSP_OP, RSP_LEN, RSP_DATA, RSP_ERR} state_t;
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] op_q, op_d, len_q, len_d, idx_q, idx_d, sum_q, sum_d;
  logic [7:0] tx_data_q, tx_data_d, err_q, err_d;
  logic [15:0] pkt_q, pkt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rx_ena_q, rx_ena_d, tx_valid_q, tx_valid_d;
  logic [7:0] mem_q [MAX_LEN];
  logic mem_we, known, err_ev, xfer;
  logic [7:0] rlen, rk, rd, rsp_byte;
  logic [AW-1:0] ra;
  always_comb begin
    known = op_q inside {OP_ECHO, OP_INV, OP_REV, OP_SUM};
    rlen = (op_q == OP_SUM) ? 8'd1 : len_q;
    // rk is the index of the byte to present after the current transfer
    rk = (state_q == RSP_DATA) ? idx_q + 8'd1 : 8'd0;
    ra = AW'((op_q == OP_REV) ? len_q - 8'd1 - rk : rk);
    rd = mem_q[ra];
    rsp_byte = (op_q == OP_INV) ? ~rd : (op_q == OP_SUM) ? sum_q : rd;
    xfer = tx_valid_q && in_tx_ready;
    state_d = state_q;
    op_d = op_q;
    len_d = len_q;
    idx_d = idx_q;
    sum_d = sum_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    pkt_d = pkt_q;
    tmo_d = '0;
    mem_we = 1'b0;
    err_ev = in_rx_valid && !rx_ena_q;
    case (state_q)
      IDLE: if (in_rx_valid) begin
        op_d = in_rx_data;
        state_d = LEN;
      end
      LEN: if (in_rx_valid) begin
        if (in_rx_data == 8'd0 || in_rx_data > MAX_LEN8) begin
          state_d = RSP_ERR;
          err_ev = 1'b1;
        end else begin
          len_d = in_rx_data;
          idx_d = 8'd0;
          sum_d = 8'd0;
          state_d = PAYLOAD;
        end
      end else if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        err_ev = 1'b1;
      end else tmo_d = tmo_q + TW'(1);
      PAYLOAD: if (in_rx_valid) begin
        mem_we = 1'b1;
        sum_d = sum_q + in_rx_data;
        idx_d = idx_q + 8'd1;
        if (idx_q == len_q - 8'd1) begin
          state_d = known ? RSP_OP : RSP_ERR;
          err_ev = !known;
        end
      end else if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        err_ev = 1'b1;
      end else tmo_d = tmo_q + TW'(1);
      RSP_OP: if (!tx_valid_q) begin
        tx_valid_d = 1'b1;
        tx_data_d = op_q;
      end else if (xfer) begin
        tx_data_d = rlen;
        state_d = RSP_LEN;
      end
      RSP_LEN: if (xfer) begin
        tx_data_d = rsp_byte;
        idx_d = 8'd0;
        state_d = RSP_DATA;
      end
      RSP_DATA: if (xfer) begin
        if (idx_q == rlen - 8'd1) begin
          tx_valid_d = 1'b0;
          pkt_d = pkt_q + 16'd1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 8'd1;
          tx_data_d = rsp_byte;
        end
      end
      RSP_ERR: if (!tx_valid_q) begin
        tx_valid_d = 1'b1;
        tx_data_d = ERR_BYTE;
      end else if (xfer) begin
        tx_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rx_ena_d = state_d inside {IDLE, LEN, PAYLOAD};
    err_d = (err_ev && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
      op_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      rx_ena_q <= 1'b1;
      err_q <= '0;
      pkt_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      len_q <= len_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ena_q <= rx_ena_d;
      err_q <= err_d;
      pkt_q <= pkt_d;
      tmo_q <= tmo_d;
    end
  end
  always_ff @(posedge in_clk) begin
    if (mem_we) mem_q[AW'(idx_q)] <= in_rx_data;
  end
  assign out_rx_ena = rx_ena_q;
  assign out_tx_data = tx_data_q;
  assign out_tx_valid = tx_valid_q;
  assign out_busy = state_q != IDLE;
  assign out_err_count = err_q;
  assign out_pkt_count = pkt_q;
endmodule
